keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 matrix keypad scan.
- Drives one row low at a time and samples the column lines on each scan-timer tick.
- Debounces press and release over consecutive ticks, then presents one encoded key code per press to the consumer through a valid/ack handshake.
- Sits between the scan-timer pulse generator and the key-consumer logic (display/decoder).

Parameters:
ROWS, 4, number of keypad rows driven
COLS, 4, number of keypad column inputs
DEBOUNCE_TICKS, 3, consecutive matching ticks required to accept a press or a release (range 1..15)

Ports:
Clock  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
ScanTick  input  1  one-cycle pulse from scan timer; all sampling/stepping happens only on cycles where it is 1
Columns  input  COLS  raw column lines, active-low (pulled up; 0 = key closed on the driven row); asynchronous to Clock
Rows  output  ROWS  row drive, active-low one-cold (exactly one bit 0)
KeyCode  output  4  encoded key = row*COLS + col, valid while KeyValid=1
KeyValid  output  1  key code available; held until Ack
Ack  input  1  consumer accepts KeyCode; sampled only while KeyValid=1
Busy  output  1  1 in DEBOUNCE and HOLD states (press in progress)

Behaviour:
- Interface: one clock (Clock); Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=SCAN, row index=0, Rows=4'b1110, KeyCode=0, KeyValid=0, Busy=0, counters=0, synchronizer flops=all-ones.
- Columns synchronization:
  - Columns passes through a 2-flop synchronizer.
  - All decisions use the synchronized value (colS) as seen on the ScanTick cycle.
- SCAN state:
  - Rows drives the current row r.
  - On ScanTick with colS all-ones: r <= (r==ROWS-1) ? 0 : r+1, and Rows updates the next cycle.
  - On ScanTick with any colS bit 0: capture pattern P=colS, capture c = lowest index with P[c]=0, row r frozen, debounce count=1, go DEBOUNCE.
  - If DEBOUNCE_TICKS=1, go directly to HOLD and issue the key in that cycle.
- DEBOUNCE state:
  - Row held. Evaluated on each ScanTick.
  - colS==P: count++. When count reaches DEBOUNCE_TICKS, KeyCode <= r*COLS+c and KeyValid <= 1 on the next edge; go HOLD.
  - colS!=P (bounce, or another key added/removed): abort to SCAN with r advanced by one; no key issued.
- HOLD state:
  - Row held.
  - A release counter counts consecutive ScanTicks with colS all-ones and resets to 0 on any tick with a 0 bit. It saturates at DEBOUNCE_TICKS.
  - Return to SCAN at r+1 only when the release counter is saturated AND KeyValid=0.
- Handshake:
  - KeyValid=1 and Ack=1 in cycle N gives KeyValid=0 at N+1.
  - Ack with KeyValid=0 is ignored.
  - KeyCode is stable while KeyValid=1 and holds its last value afterwards.
  - Ack may arrive before or after release. One key per press; no auto-repeat.
- Latency: the key is issued on the cycle after the DEBOUNCE_TICKS-th matching tick. The first tick of a press is counted in SCAN.
- Ticks between events: non-tick cycles change no state except the synchronizer and the Ack handling.
- Multiple keys on one row: lowest column wins. Keys on other rows are invisible until the scan returns to them.
- Reset mid-press (DEBOUNCE/HOLD): immediate return to reset values; a pending KeyValid is dropped.
- Busy: 1 exactly when state is DEBOUNCE or HOLD.

Decomposition:
- Package keypad_pkg: state enum {SCAN, DEBOUNCE, HOLD}, KEYCODE_W=4, COLS_IDLE='1 constant.
- Sub-module keypad_sync: parameterised-width 2-flop synchronizer with synchronous active-high reset to all-ones.
- Remaining logic (FSM, row counter, debounce/release counters, priority encoder) lives in keypad_scan_ctrl.

Test Plan:
- Scan rotation: ScanTick every 4 cycles, Columns=4'b1111 → Rows steps 1110→1101→1011→0111→1110; KeyValid stays 0, Busy stays 0.
- Clean press: Columns=4'b1011 (col 2) while Rows=1101 (row 1), held stable → after the 3rd tick KeyValid=1, KeyCode=6; Rows stays 1101; Ack pulse → KeyValid=0 next cycle.
- Bounce reject: col 0 low for 1 tick on row 3, then high → no KeyValid; back in SCAN driving Rows=1110.
- Ack before release: key 9 accepted and Ack'd, key held 10 more ticks → no second KeyValid; release held 3 ticks → scan resumes at the next row.
- Release before Ack / simultaneous keys: cols 1 and 3 low on row 0 → KeyCode=1; release debounced; FSM stays HOLD until Ack, then SCAN.
- Reset mid-operation: assert Reset for 1 cycle while KeyValid=1 in HOLD → next cycle KeyValid=0, Busy=0, Rows=1110, KeyCode=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding and constants for the keypad scan controller
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;
    localparam int KEYCODE_W = 4;
    localparam logic [15:0] COLS_IDLE = '1;
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer resetting to all-ones (idle pulled-up lines)
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge Clock) begin
        if (Reset) {q, meta} <= '1;
        else       {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with press/release debounce and a valid/ack key output
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ScanTick,
    input  logic [COLS-1:0]      Columns,
    output logic [ROWS-1:0]      Rows,
    output logic [KEYCODE_W-1:0] KeyCode,
    output logic                 KeyValid,
    input  logic                 Ack,
    output logic                 Busy
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);
    state_t state, state_n;
    logic [RW-1:0] row, row_n, row_inc;
    logic [CW-1:0] col, col_n, low;
    logic [COLS-1:0] col_s, pat, pat_n;
    logic [3:0] cnt, cnt_n, rel, rel_n;
    logic [KEYCODE_W-1:0] code_n;
    logic valid_n, idle;
    keypad_sync #(.W(COLS)) u_sync (.Clock(Clock), .Reset(Reset), .d(Columns), .q(col_s));
    assign idle    = col_s == COLS_IDLE[COLS-1:0];
    assign row_inc = row == RW'(ROWS - 1) ? '0 : row + 1'b1;
    assign Rows    = ~(ROWS'(1) << row);
    assign Busy    = state != SCAN;
    // lowest closed column wins when several keys share the driven row
    always_comb begin
        low = '0;
        for (int i = COLS - 1; i >= 0; i--) low = col_s[i] ? low : CW'(i);
    end
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        pat_n   = pat;
        cnt_n   = cnt;
        rel_n   = rel;
        code_n  = KeyCode;
        valid_n = KeyValid & ~Ack;
        if (ScanTick) begin
            case (state)
                SCAN: begin
                    row_n   = idle ? row_inc : row;
                    pat_n   = idle ? pat : col_s;
                    col_n   = idle ? col : low;
                    cnt_n   = idle ? cnt : 4'd1;
                    rel_n   = idle ? rel : 4'd0;
                    state_n = idle ? SCAN : (DT == 4'd1 ? HOLD : DEBOUNCE);
                    valid_n = valid_n | (!idle && DT == 4'd1);
                    code_n  = (!idle && DT == 4'd1) ? KEYCODE_W'(int'(row) * COLS + int'(low)) : KeyCode;
                end
                DEBOUNCE: begin
                    if (col_s != pat) begin
                        state_n = SCAN;
                        row_n   = row_inc;
                    end else if (cnt + 4'd1 == DT) begin
                        state_n = HOLD;
                        valid_n = 1'b1;
                        code_n  = KEYCODE_W'(int'(row) * COLS + int'(col));
                        rel_n   = 4'd0;
                    end else cnt_n = cnt + 4'd1;
                end
                HOLD: begin
                    rel_n = idle ? (rel == DT ? rel : rel + 4'd1) : 4'd0;
                    if (rel_n == DT && !KeyValid) begin
                        state_n = SCAN;
                        row_n   = row_inc;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= SCAN;
            row      <= '0;
            col      <= '0;
            pat      <= '1;
            cnt      <= '0;
            rel      <= '0;
            KeyCode  <= '0;
            KeyValid <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            col      <= col_n;
            pat      <= pat_n;
            cnt      <= cnt_n;
            rel      <= rel_n;
            KeyCode  <= code_n;
            KeyValid <= valid_n;
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for scan rotation, debounce, handshake and reset
module tb_keypad_scan_ctrl;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       ScanTick = 1'b0;
    logic [3:0] Columns = 4'hF;
    logic [3:0] Rows;
    logic [3:0] KeyCode;
    logic       KeyValid;
    logic       Ack = 1'b0;
    logic       Busy;
    int n_cmp = 0;
    int n_err = 0;
    keypad_scan_ctrl dut (
        .Clock(Clock), .Reset(Reset), .ScanTick(ScanTick), .Columns(Columns),
        .Rows(Rows), .KeyCode(KeyCode), .KeyValid(KeyValid), .Ack(Ack), .Busy(Busy)
    );
    always #5 Clock = ~Clock;
    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask
    task automatic tick();
        ScanTick = 1'b1;
        cyc(1);
        ScanTick = 1'b0;
        cyc(3);
    endtask
    task automatic setc(input logic [3:0] v);
        Columns = v;
        cyc(2);
    endtask
    task automatic ack_pulse();
        Ack = 1'b1;
        cyc(1);
        Ack = 1'b0;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic [3:0] r, input logic v, input logic b);
        chk({tag, ".rows"}, 32'(Rows), 32'(r));
        chk({tag, ".valid"}, 32'(KeyValid), 32'(v));
        chk({tag, ".busy"}, 32'(Busy), 32'(b));
    endtask
    initial begin
        cyc(2);
        Reset = 1'b0;
        chk_out("reset", 4'hE, 1'b0, 1'b0);
        chk("reset.code", 32'(KeyCode), 32'h0);
        // scan rotation with all columns open
        tick(); chk_out("rot1", 4'hD, 1'b0, 1'b0);
        tick(); chk_out("rot2", 4'hB, 1'b0, 1'b0);
        tick(); chk_out("rot3", 4'h7, 1'b0, 1'b0);
        tick(); chk_out("rot4", 4'hE, 1'b0, 1'b0);
        // clean press row 1 col 2 -> key 6
        tick(); chk_out("p.row1", 4'hD, 1'b0, 1'b0);
        setc(4'b1011);
        tick(); chk_out("p.t1", 4'hD, 1'b0, 1'b1);
        tick(); chk_out("p.t2", 4'hD, 1'b0, 1'b1);
        tick(); chk_out("p.t3", 4'hD, 1'b1, 1'b1);
        chk("p.code", 32'(KeyCode), 32'd6);
        ack_pulse();
        chk("p.ack", 32'(KeyValid), 32'd0);
        chk("p.codehold", 32'(KeyCode), 32'd6);
        setc(4'hF);
        tick(); tick(); chk_out("p.rel2", 4'hD, 1'b0, 1'b1);
        tick(); chk_out("p.rel3", 4'hB, 1'b0, 1'b0);
        // one-tick bounce on row 3 col 0 is rejected
        tick(); chk_out("b.row3", 4'h7, 1'b0, 1'b0);
        setc(4'b1110);
        tick(); chk_out("b.t1", 4'h7, 1'b0, 1'b1);
        setc(4'hF);
        tick(); chk_out("b.abort", 4'hE, 1'b0, 1'b0);
        // key 9 acked while still held: no repeat
        tick(); tick(); chk_out("h.row2", 4'hB, 1'b0, 1'b0);
        setc(4'b1101);
        tick(); tick(); tick(); chk_out("h.issue", 4'hB, 1'b1, 1'b1);
        chk("h.code", 32'(KeyCode), 32'd9);
        ack_pulse();
        chk("h.ack", 32'(KeyValid), 32'd0);
        repeat (10) tick();
        chk_out("h.held", 4'hB, 1'b0, 1'b1);
        setc(4'hF);
        tick(); tick(); chk_out("h.rel2", 4'hB, 1'b0, 1'b1);
        tick(); chk_out("h.rel3", 4'h7, 1'b0, 1'b0);
        // cols 1 and 3 on row 0, release before ack
        tick(); chk_out("s.row0", 4'hE, 1'b0, 1'b0);
        setc(4'b0101);
        tick(); tick(); tick(); chk_out("s.issue", 4'hE, 1'b1, 1'b1);
        chk("s.code", 32'(KeyCode), 32'd1);
        setc(4'hF);
        tick(); tick(); tick(); chk_out("s.rel3", 4'hE, 1'b1, 1'b1);
        tick(); chk_out("s.rel4", 4'hE, 1'b1, 1'b1);
        ack_pulse();
        chk_out("s.ack", 4'hE, 1'b0, 1'b1);
        tick(); chk_out("s.scan", 4'hD, 1'b0, 1'b0);
        ack_pulse();
        chk_out("s.idleack", 4'hD, 1'b0, 1'b0);
        // reset while a key is pending in HOLD
        setc(4'b1110);
        tick(); tick(); tick(); chk_out("r.issue", 4'hD, 1'b1, 1'b1);
        chk("r.code", 32'(KeyCode), 32'd4);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        chk_out("r.after", 4'hE, 1'b0, 1'b0);
        chk("r.code0", 32'(KeyCode), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
